wb_decoder_n: RTL and testbench
===============================

// Module: wb_decoder_n
// PURPOSE
//  Parametrised NS-slave Wishbone (classic, single outstanding) address decoder/arbiter between the
//  picorv32 wishbone master and SoC peripherals (LEDs, CDT, UART, GPIOx). Decodes by base/mask per
//  slave, registers one transaction, muxes the response back, and reports unmapped/slave/timeout
//  errors with a captured address and code. Supersedes the fixed three-slave interconnect.
// PARAMETERS
//  NS          4                       number of slave ports (1..16)
//  AW          32                      address width
//  DW          32                      data width (sel width = DW/8)
//  SLAVE_BASE  {NS{32'h0}}             NS*AW flattened; slot k = bits [k*AW +: AW]
//  SLAVE_MASK  {NS{32'hFFFF_FFFF}}     NS*AW flattened; slave k hit when (addr & MASK_k) == BASE_k
//  TIMEOUT     255                     max WAIT cycles before timeout error (>=2)
// PORTS
//  i_clk             in   1       clock
//  i_resetn          in   1       synchronous reset, active low
//  i_wb_addr         in   AW      master address
//  i_wb_data         in   DW      master write data
//  i_wb_sel          in   DW/8    byte selects
//  i_wb_we           in   1       write enable
//  i_wb_cyc          in   1       cycle
//  i_wb_stb          in   1       strobe
//  o_wb_ack          out  1       one-cycle ack to master
//  o_wb_data         out  DW      read data, valid with o_wb_ack
//  o_wb_stall        out  1       high whenever not IDLE
//  o_wb_err          out  1       one-cycle error pulse (replaces ack)
//  o_wb_err_address  out  AW      address of last errored request
//  o_wb_err_code     out  2       last error: 00 none, 01 unmapped, 10 slave err, 11 timeout
//  o_s_addr/o_s_data/o_s_sel/o_s_we  out AW/DW/DW/8/1  registered request, shared by all slaves
//  o_s_cyc           out  NS      one-hot cyc to selected slave
//  o_s_stb           out  NS      one-hot stb to selected slave
//  i_s_ack/i_s_err/i_s_stall  in  NS  per-slave response
//  i_s_data          in   NS*DW   flattened slave read data
// BEHAVIOUR
//  - Reset (i_resetn=0 at edge): state IDLE; all outputs 0, incl. err_address/err_code; wins over all.
//  - FSM IDLE/REQ/WAIT/RESP. IDLE: on cyc&stb, decode; lowest-index hit wins on overlap.
//    hit -> latch addr/data/sel/we + index, REQ. miss -> capture addr, code 01, RESP(err).
//  - REQ: o_s_cyc[k]=o_s_stb[k]=1; stb drops the cycle after i_s_stall[k]=0 -> WAIT
//    (ack/err seen in REQ with stall=0 is accepted immediately -> RESP).
//  - WAIT: o_s_cyc[k]=1, stb=0; i_s_ack[k] -> register i_s_data[k], RESP(ack); i_s_err[k] -> code 10,
//    RESP(err); ack&err same cycle -> err wins. Responses from non-selected slaves ignored.
//  - RESP: o_wb_ack or o_wb_err high exactly 1 cycle, o_s_cyc=0 -> IDLE. o_wb_data=0 unless ack.
//  - Latency: request seen at T, slave stb T+1; slave ack at T+n -> master ack T+n+1.
//  - Master drops i_wb_cyc in REQ/WAIT: abort, o_s_cyc/stb=0 next cycle, IDLE, no ack/err.
//  - err_address/err_code hold until next error; overwritten, never cleared except by reset.
// CONFIGURATION
//  WB_DECODER_TIMEOUT_EN defined: TIMEOUT-cycle counter runs in REQ+WAIT (clears on entry);
//   on reaching TIMEOUT with no ack/err: drop slave cyc, code 11, RESP(err). Ack on the same cycle
//   as expiry wins. Undefined: no counter, WAIT may hang indefinitely; code 11 never produced.
// TESTING
//  1 NS=3 bases 8000_0000/8000_0010/8000_0020, masks FFFF_FFFF/FFFF_FFF0/FFFF_FFFE; write 0x2A to
//    8000_0000, slave0 acks after 2 cycles -> o_s_stb=3'b001, o_wb_ack at T+4, code stays 00.
//  2 Read 8000_0021, slave2 stalls 3 cycles, acks with 0xDEAD_BEEF -> stb held 4 cycles,
//    o_wb_data=DEAD_BEEF with ack, slaves 0/1 never strobed.
//  3 Read 9000_0000 -> no slave stb, o_wb_err at T+1, err_address=9000_0000, code 01.
//  4 Slave1 asserts ack+err together -> o_wb_err only, code 10, err_address=8000_0014.
//  5 TIMEOUT_EN, TIMEOUT=8, silent slave -> o_wb_err 9 cycles after request, code 11, o_s_cyc=0.
//  6 Reset mid-WAIT and cyc drop mid-WAIT -> IDLE next cycle, no ack/err, resets zero err regs.

Source files
------------

// File: rtl/wb_decoder_n_if.sv
// Master-side Wishbone (classic) bus between the CPU master and the wb_decoder_n interconnect.
interface wb_decoder_n_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic            ack;
  logic [DW-1:0]   rdata;
  logic            stall;
  logic            err;
  logic [AW-1:0]   err_address;
  logic [1:0]      err_code;

  modport master (
    output addr, wdata, sel, we, cyc, stb,
    input  ack, rdata, stall, err, err_address, err_code
  );

  modport slave (
    input  addr, wdata, sel, we, cyc, stb,
    output ack, rdata, stall, err, err_address, err_code
  );
endinterface

// File: rtl/wb_decoder_n.sv
// NS-slave Wishbone classic decoder: base/mask decode, one registered transaction, error capture.
// Define WB_DECODER_TIMEOUT_EN to enable the REQ/WAIT timeout counter (error code 11).
module wb_decoder_n #(
  parameter int unsigned      NS         = 4,
  parameter int unsigned      AW         = 32,
  parameter int unsigned      DW         = 32,
  parameter logic [NS*AW-1:0] SLAVE_BASE = '0,
  parameter logic [NS*AW-1:0] SLAVE_MASK = '1,
  parameter int unsigned      TIMEOUT    = 255
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  wb_decoder_n_if.slave      wb,
  output logic [AW-1:0]      o_s_addr,
  output logic [DW-1:0]      o_s_data,
  output logic [DW/8-1:0]    o_s_sel,
  output logic               o_s_we,
  output logic [NS-1:0]      o_s_cyc,
  output logic [NS-1:0]      o_s_stb,
  input  logic [NS-1:0]      i_s_ack,
  input  logic [NS-1:0]      i_s_err,
  input  logic [NS-1:0]      i_s_stall,
  input  logic [NS*DW-1:0]   i_s_data
);

  localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;

  if (NS < 1 || NS > 16) begin : g_bad_ns
    $error("wb_decoder_n: NS must be in 1..16");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("wb_decoder_n: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic            we_q, we_d;
  logic            resp_err_q, resp_err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   err_addr_q, err_addr_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic            sel_ack, sel_err, sel_stall;
  logic [DW-1:0]   sel_data;
  logic            rsp_take;
  logic            tmo_hit;
  logic [NS-1:0]   onehot;

  // Ascending scan with first-match latch gives lowest-index priority on overlapping windows.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (!hit && ((wb.addr & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW])) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  assign sel_ack   = i_s_ack[idx_q];
  assign sel_err   = i_s_err[idx_q];
  assign sel_stall = i_s_stall[idx_q];
  assign sel_data  = i_s_data[idx_q*DW +: DW];
  assign rsp_take  = (state_q == S_WAIT) || !sel_stall;

`ifdef WB_DECODER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmo_q, tmo_d;

  // Counts REQ+WAIT cycles from zero; the TIMEOUT-th such cycle is the last chance to respond.
  always_comb begin
    tmo_d = '0;
    if (state_q == S_REQ || state_q == S_WAIT) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    we_d       = we_q;
    resp_err_d = resp_err_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    err_code_d = err_code_q;
    unique case (state_q)
      S_IDLE: begin
        if (wb.cyc && wb.stb) begin
          if (hit) begin
            idx_d   = hit_idx;
            addr_d  = wb.addr;
            wdata_d = wb.wdata;
            sel_d   = wb.sel;
            we_d    = wb.we;
            state_d = S_REQ;
          end else begin
            err_addr_d = wb.addr;
            err_code_d = 2'b01;
            resp_err_d = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_REQ, S_WAIT: begin
        if (!wb.cyc) begin
          state_d = S_IDLE;
        end else if (rsp_take && (sel_ack || sel_err)) begin
          state_d = S_RESP;
          if (sel_err) begin
            err_addr_d = addr_q;
            err_code_d = 2'b10;
            resp_err_d = 1'b1;
          end else begin
            rdata_d    = sel_data;
            resp_err_d = 1'b0;
          end
        end else if (tmo_hit) begin
          err_addr_d = addr_q;
          err_code_d = 2'b11;
          resp_err_d = 1'b1;
          state_d    = S_RESP;
        end else if (state_q == S_REQ && !sel_stall) begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      resp_err_q <= 1'b0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      resp_err_q <= resp_err_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
      err_code_q <= err_code_d;
    end
  end

  assign onehot = NS'(1'b1) << idx_q;

  assign o_s_addr = addr_q;
  assign o_s_data = wdata_q;
  assign o_s_sel  = sel_q;
  assign o_s_we   = we_q;
  assign o_s_cyc  = (state_q == S_REQ || state_q == S_WAIT) ? onehot : '0;
  assign o_s_stb  = (state_q == S_REQ) ? onehot : '0;

  assign wb.ack         = (state_q == S_RESP) && !resp_err_q;
  assign wb.err         = (state_q == S_RESP) && resp_err_q;
  assign wb.rdata       = wb.ack ? rdata_q : '0;
  assign wb.stall       = (state_q != S_IDLE);
  assign wb.err_address = err_addr_q;
  assign wb.err_code    = err_code_q;

endmodule

// File: tb/tb_wb_decoder_n.sv
// Randomised scoreboard bench for wb_decoder_n with scripted slave responders and a behavioural model.
module tb_wb_decoder_n;
  localparam int unsigned NS = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam logic [NS*AW-1:0] BASES = {32'h8000_0020, 32'h8000_0010, 32'h8000_0000};
  localparam logic [NS*AW-1:0] MASKS = {32'hFFFF_FFFE, 32'hFFFF_FFF0, 32'hFFFF_FFFF};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  wb_decoder_n_if #(.AW(AW), .DW(DW)) wb ();
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_data;
  logic [DW/8-1:0]  s_sel;
  logic             s_we;
  logic [NS-1:0]    s_cyc, s_stb, s_ack, s_err, s_stall;
  logic [NS*DW-1:0] s_rdata;

  wb_decoder_n #(
    .NS(NS), .AW(AW), .DW(DW), .SLAVE_BASE(BASES), .SLAVE_MASK(MASKS), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_resetn(resetn), .wb(wb),
    .o_s_addr(s_addr), .o_s_data(s_data), .o_s_sel(s_sel), .o_s_we(s_we),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb),
    .i_s_ack(s_ack), .i_s_err(s_err), .i_s_stall(s_stall), .i_s_data(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    logic [1:0]  code;
    logic [31:0] eaddr;
    int unsigned cyc;
    int unsigned stbs;
  } exp_t;

  exp_t        q[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc_n = 0;
  logic        cyc_prev = 1'b0;
  logic        rst_prev = 1'b0;
  int unsigned stb_cnt = 0;
  logic [1:0]  m_code = 2'b00;
  logic [31:0] m_eaddr = '0;
  logic [NS-1:0] cur_oh = '0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic [3:0]  cur_sel = '0;
  logic        cur_we = 1'b0;

  logic [31:0] base_a [NS] = '{32'h8000_0000, 32'h8000_0010, 32'h8000_0020};
  logic [31:0] mask_a [NS] = '{32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFE};

  function automatic int ref_decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++) begin
      if ((a & mask_a[k]) == base_a[k]) return k;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  always @(posedge clk) begin
    cyc_n    <= cyc_n + 1;
    cyc_prev <= wb.cyc;
    rst_prev <= resetn;
  end

  // Monitor: compares every response pulse against the queue head and checks slave-side strobes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_prev) begin
      check("reset_outputs", {wb.ack, wb.err, wb.stall, s_cyc, s_stb, wb.err_code,
                              |wb.err_address, |wb.rdata, |s_addr, |s_data, |s_sel, s_we}, '0);
      stb_cnt = 0;
    end else if (!cyc_prev) begin
      check("idle_after_cyc_low", {wb.ack, wb.err, wb.stall, s_cyc, s_stb}, '0);
      stb_cnt = 0;
    end else begin
      if (|s_stb) begin
        stb_cnt++;
        check("stb_target", s_stb, cur_oh);
        check("s_addr_data", {s_addr, s_data}, {cur_addr, cur_wdata});
        check("s_sel_we", {s_sel, s_we}, {cur_sel, cur_we});
      end
      if (|s_cyc) check("cyc_target", s_cyc, cur_oh);
      if (wb.ack || wb.err) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got ack=%b err=%b with nothing outstanding", wb.ack, wb.err);
        end else begin
          e = q.pop_front();
          check("resp_kind", {wb.ack, wb.err}, {~e.is_err, e.is_err});
          check("resp_cycle", cyc_n, e.cyc);
          check("resp_data", wb.rdata, e.is_err ? 32'h0 : e.data);
          check("err_code", wb.err_code, e.code);
          check("err_address", wb.err_address, e.eaddr);
          check("stb_cycles", stb_cnt, e.stbs);
          check("s_cyc_in_resp", s_cyc, '0);
        end
        stb_cnt = 0;
      end else begin
        check("rdata_zero", wb.rdata, '0);
      end
    end
  end

  // kind: 0 ack, 1 err, 2 ack+err, 3 silent. abort_k>0 drops cyc (or resets) in that cycle after T.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sl,
                         input logic we, input int s, input int d, input int kind, input bit early,
                         input logic [31:0] rd, input int abort_k, input bit use_rst);
    int tgt, krs, lat, end_k, ab;
    bit aborted;
    exp_t e;
    @(negedge clk);
    resetn = 1'b1;
    tgt = ref_decode(a);
    ab = abort_k;
    krs = -1;
    e.data = rd; e.code = m_code; e.eaddr = m_eaddr; e.is_err = 1'b0; e.stbs = 0;
    if (tgt < 0) begin
      lat = 1; e.is_err = 1'b1; e.code = 2'b01; e.eaddr = a;
    end else begin
      krs = (kind == 3) ? 1000 : (early ? s + 1 : s + 2 + d);
      lat = krs + 1;
      e.stbs = s + 1;
      if (kind == 1 || kind == 2) begin
        e.is_err = 1'b1; e.code = 2'b10; e.eaddr = a;
      end
`ifdef WB_DECODER_TIMEOUT_EN
      if (lat > TIMEOUT + 1) begin
        lat = TIMEOUT + 1; krs = -1;
        e.is_err = 1'b1; e.code = 2'b11; e.eaddr = a;
        e.stbs = (s + 1 < TIMEOUT) ? s + 1 : TIMEOUT;
      end
`else
      if (kind == 3 && ab == 0) ab = 2;
`endif
    end
    aborted = (tgt >= 0) && (ab > 0) && (ab < lat);
    e.cyc = cyc_n + lat;
    cur_oh = '0;
    if (tgt >= 0) cur_oh[tgt] = 1'b1;
    cur_addr = a; cur_wdata = wd; cur_sel = sl; cur_we = we;
    wb.addr = a; wb.wdata = wd; wb.sel = sl; wb.we = we; wb.cyc = 1'b1; wb.stb = 1'b1;
    if (!aborted) begin
      q.push_back(e);
      m_code = e.code;
      m_eaddr = e.eaddr;
    end
    end_k = aborted ? ab : lat;
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      for (int j = 0; j < NS; j++) begin
        s_ack[j] = 1'($urandom_range(0, 1));
        s_err[j] = 1'($urandom_range(0, 1));
        s_stall[j] = 1'($urandom_range(0, 1));
        s_rdata[j*32 +: 32] = $urandom;
      end
      if (k == end_k) begin
        wb.cyc = 1'b0; wb.stb = 1'b0;
        s_ack = '0; s_err = '0; s_stall = '0;
        if (aborted && use_rst) begin
          resetn = 1'b0; m_code = 2'b00; m_eaddr = '0;
        end
      end else if (tgt >= 0) begin
        s_stall[tgt] = (k <= s);
        s_ack[tgt] = (k == krs) && (kind == 0 || kind == 2);
        s_err[tgt] = (k == krs) && (kind == 1 || kind == 2);
        if (k == krs) s_rdata[tgt*32 +: 32] = rd;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int s, d, kind, ab;
    bit early, rs;
    wb.addr = '0; wb.wdata = '0; wb.sel = '0; wb.we = 1'b0; wb.cyc = 1'b0; wb.stb = 1'b0;
    s_ack = '0; s_err = '0; s_stall = '0; s_rdata = '0;
    repeat (2) @(negedge clk);
    run_txn(32'h8000_0000, 32'h0000_002A, 4'hF, 1'b1, 0, 1, 0, 1'b0, 32'h0, 0, 1'b0);
    run_txn(32'h8000_0021, 32'h0, 4'hF, 1'b0, 3, 0, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    run_txn(32'h9000_0000, 32'h0, 4'hF, 1'b0, 0, 0, 0, 1'b0, 32'h0, 0, 1'b0);
    run_txn(32'h8000_0014, 32'h0, 4'hF, 1'b0, 0, 1, 2, 1'b0, 32'h1234_5678, 0, 1'b0);
`ifdef WB_DECODER_TIMEOUT_EN
    run_txn(32'h8000_0000, 32'h0, 4'hF, 1'b0, 0, 0, 3, 1'b0, 32'h0, 0, 1'b0);
    run_txn(32'h8000_0010, 32'h0, 4'hF, 1'b0, 0, 6, 0, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
`endif
    run_txn(32'h8000_0012, 32'h55, 4'h3, 1'b1, 0, 4, 0, 1'b0, 32'h0, 3, 1'b0);
    run_txn(32'h8000_0020, 32'h66, 4'h1, 1'b1, 0, 4, 0, 1'b0, 32'h0, 3, 1'b1);
    run_txn(32'h8000_0000, 32'h77, 4'hF, 1'b1, 1, 0, 0, 1'b1, 32'hA5A5_5A5A, 0, 1'b0);
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'h8000_0010 | 32'($urandom_range(0, 15));
        2: a = 32'h8000_0020 | 32'($urandom_range(0, 1));
        3: a = 32'h8000_0001 + 32'($urandom_range(0, 14));
        4: a = 32'h8000_0022 + 32'($urandom_range(0, 13));
        default: a = $urandom;
      endcase
      s = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) s = $urandom_range(4, 10);
      d = $urandom_range(0, 6);
      kind = $urandom_range(0, 3);
      early = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      rs = 1'($urandom_range(0, 1));
      run_txn(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              s, d, kind, early, $urandom, ab, rs);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
